// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch unit:
// FSM encoding, fetch base address, header length and per-state status flags.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0] IM_BASE = 32'h0000_3000;
  localparam int          HDR_LEN = 2;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic err;
    logic cpu_hold;
  } status_t;

  // Status flags are a pure function of the state being entered, so the
  // loader can register them alongside the state itself.
  function automatic status_t status_of(state_t s);
    status_t r;
    r          = '0;
    r.in_ready = (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CSUM);
    r.busy     = r.in_ready;
    r.done     = (s == S_DONE);
    r.err      = (s == S_ERR);
    r.cpu_hold = (s != S_DONE);
    return r;
  endfunction

  // Fetch address of a byte held in instruction memory.
  function automatic logic [31:0] fetch_addr(logic [31:0] byte_addr);
    return IM_BASE + byte_addr;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the loader and byte-write port out to instruction memory.
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready are both high.
interface imem_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [7:0]        im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a counted, checksummed byte stream into instruction memory while
// holding the processor in reset; releases it once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IM_BYTES = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.master   bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err,
  output state_t          state_dbg
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [15:0] MAX_WORDS = 16'(IM_BYTES / 4);

  state_t           state;
  status_t          st;
  logic [7:0]       count_hi;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] total_bytes;
  logic [7:0]       sum;
  logic [15:0]      n_words;

  assign n_words      = {count_hi, bus.in_data};
  assign bus.in_ready = st.in_ready;
  assign cpu_hold     = st.cpu_hold;
  assign busy         = st.busy;
  assign done         = st.done;
  assign err          = st.err;
  assign state_dbg    = state;

  // in_ready is high exactly in the accepting states, so in_valid alone
  // marks a transfer inside those branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      st           <= status_of(S_IDLE);
      count_hi     <= '0;
      byte_cnt     <= '0;
      total_bytes  <= '0;
      sum          <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR_HI;
            st       <= status_of(S_HDR_HI);
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        S_HDR_HI: begin
          if (bus.in_valid) begin
            count_hi <= bus.in_data;
            state    <= S_HDR_LO;
            st       <= status_of(S_HDR_LO);
          end
        end
        S_HDR_LO: begin
          if (bus.in_valid) begin
            total_bytes <= CNT_W'({n_words, 2'b00});
            if (n_words > MAX_WORDS) begin
              state <= S_ERR;
              st    <= status_of(S_ERR);
            end else if (n_words == 16'd0) begin
              state <= S_CSUM;
              st    <= status_of(S_CSUM);
            end else begin
              state <= S_DATA;
              st    <= status_of(S_DATA);
            end
          end
        end
        S_DATA: begin
          if (bus.in_valid) begin
            bus.im_we    <= 1'b1;
            bus.im_addr  <= byte_cnt[ADDR_W-1:0];
            bus.im_wdata <= bus.in_data;
            sum          <= sum + bus.in_data;
            byte_cnt     <= byte_cnt + 1'b1;
            if (byte_cnt + 1'b1 == total_bytes) begin
              state <= S_CSUM;
              st    <= status_of(S_CSUM);
            end
          end
        end
        S_CSUM: begin
          if (bus.in_valid) begin
            if (8'(sum + bus.in_data) == 8'd0) begin
              state <= S_DONE;
              st    <= status_of(S_DONE);
            end else begin
              state <= S_ERR;
              st    <= status_of(S_ERR);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          st    <= status_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random streams checked against a
// stream-level reference model and an expected-write queue.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int IM_BYTES = 1024;
  localparam int ADDR_W   = 10;

  logic   clk = 1'b0;
  logic   reset;
  logic   start;
  logic   cpu_hold, busy, done, err;
  state_t state_dbg;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.IM_BYTES(IM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int                total = 0;
  int                bad   = 0;
  logic [7:0]        stream_q[$];
  logic [ADDR_W+7:0] exp_q[$];
  int                exp_words;
  bit                exp_hdr_err;
  bit                exp_ok;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: derive the expected writes and the outcome from the raw stream.
  task automatic model_load();
    int s;
    exp_words   = int'(stream_q[0]) * 256 + int'(stream_q[1]);
    exp_hdr_err = exp_words > IM_BYTES / 4;
    exp_q.delete();
    exp_ok = 1'b0;
    if (!exp_hdr_err) begin
      s = 0;
      for (int i = 0; i < 4 * exp_words; i++) begin
        exp_q.push_back({ADDR_W'(i), stream_q[HDR_LEN + i]});
        s += int'(stream_q[HDR_LEN + i]);
      end
      exp_ok = ((s + int'(stream_q[HDR_LEN + 4 * exp_words])) % 256) == 0;
    end
  endtask

  task automatic build_stream(input int n, input bit good_csum);
    int s;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n >> 8));
    stream_q.push_back(8'(n));
    if (n <= IM_BYTES / 4) begin
      s = 0;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom_range(0, 255));
        stream_q.push_back(b);
        s += int'(b);
      end
      if (good_csum) stream_q.push_back(8'(256 - (s % 256)));
      else           stream_q.push_back(8'(256 - (s % 256) + int'($urandom_range(1, 255))));
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_state", 32'(state_dbg), 32'(S_HDR_HI));
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_err", err, 0);
    check_eq("start_hold", cpu_hold, 1);
    check_eq("start_ready", bus.in_ready, 1);
  endtask

  // mode 0: in_valid always high, 1: toggling, 2: random.
  task automatic send(input int mode, input int stop_after, input int start_at);
    int   i = 0;
    int   len;
    int   stall = 0;
    bit   pend = 1'b0;
    bit   fired = 1'b0;
    bit   tog = 1'b1;
    bit   v;
    bit   x;
    logic [ADDR_W+7:0] e;
    len = exp_hdr_err ? HDR_LEN : HDR_LEN + 4 * exp_words + 1;
    if (stop_after >= 0 && stop_after < len) len = stop_after;
    forever begin
      @(negedge clk);
      check_eq("im_we", bus.im_we, pend);
      if (pend && bus.im_we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("im_addr", bus.im_addr, e[ADDR_W+7:8]);
        check_eq("im_wdata", bus.im_wdata, e[7:0]);
      end
      start = 1'b0;
      if (i >= len) break;
      if (start_at == i && !fired) begin
        start = 1'b1;
        fired = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = $urandom_range(0, 2) != 0;
      endcase
      bus.in_valid = v;
      bus.in_data  = stream_q[i];
      x    = v && bus.in_ready;
      pend = x && !exp_hdr_err && (i >= HDR_LEN) && (i < HDR_LEN + 4 * exp_words);
      stall = (v && !bus.in_ready) ? stall + 1 : 0;
      if (stall > 8) begin
        check_eq("ready_timeout", 1, 0);
        break;
      end
      if (x) i++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_end();
    check_eq("end_done", done, exp_ok);
    check_eq("end_err", err, !exp_ok);
    check_eq("end_hold", cpu_hold, !exp_ok);
    check_eq("end_busy", busy, 0);
    check_eq("end_ready", bus.in_ready, 0);
    check_eq("end_state", 32'(state_dbg), exp_ok ? 32'(S_DONE) : 32'(S_ERR));
    repeat (2) begin
      @(negedge clk);
      check_eq("end_no_we", bus.im_we, 0);
    end
    check_eq("end_exp_left", exp_q.size(), 0);
  endtask

  task automatic run(input int mode);
    model_load();
    pulse_start();
    send(mode, -1, -1);
    check_end();
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check_eq("rst_ready", bus.in_ready, 0);
    check_eq("rst_we", bus.im_we, 0);
    check_eq("rst_addr", bus.im_addr, 0);
    check_eq("rst_wdata", bus.im_wdata, 0);
    check_eq("rst_hold", cpu_hold, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_ready", bus.in_ready, 0);

    // Four-byte program with matching checksum.
    stream_q = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'hCF};
    run(0);

    // Empty program: good and bad checksum.
    stream_q = '{8'h00, 8'h00, 8'h00};
    run(0);
    stream_q = '{8'h00, 8'h00, 8'h01};
    run(0);

    // Oversize word count stops after the header.
    stream_q = '{8'h01, 8'h01};
    run(0);

    // Largest legal program, then a throttled producer.
    build_stream(IM_BYTES / 4, 1'b1);
    run(0);
    build_stream(2, 1'b1);
    run(1);

    // Reset after two data bytes aborts the load at once.
    build_stream(4, 1'b1);
    model_load();
    pulse_start();
    send(0, HDR_LEN + 2, -1);
    #1 reset = 1'b1;
    #1;
    check_eq("abort_we", bus.im_we, 0);
    check_eq("abort_state", 32'(state_dbg), 32'(S_IDLE));
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", bus.in_ready, 0);
    check_eq("abort_hold", cpu_hold, 1);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_eq("abort_stays_idle", 32'(state_dbg), 32'(S_IDLE));
    build_stream(3, 1'b1);
    run(0);

    // start during DATA is ignored; start in DONE restarts the header.
    build_stream(3, 1'b1);
    model_load();
    pulse_start();
    send(0, -1, HDR_LEN + 3);
    check_end();
    pulse_start();
    build_stream(1, 1'b0);
    model_load();
    send(2, -1, -1);
    check_end();

    // Random streams.
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 7) == 0) build_stream(int'($urandom_range(257, 65535)), 1'b1);
      else build_stream(int'($urandom_range(0, 9)), $urandom_range(0, 3) != 0);
      run(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IM_BYTES, default 1024, capacity of the byte-addressed instruction memory.
REQ-002 Parameter ADDR_W, default 10, byte-address width, equal to log2(IM_BYTES).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 in_valid  input  1  producer has a byte on in_data.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 im_we  output  1  byte write strobe to instruction memory.
REQ-010 im_addr  output  ADDR_W  byte address of the write; byte 0 is fetch address 0x0000_3000.
REQ-011 im_wdata  output  8  byte to write.
REQ-012 cpu_hold  output  1  holds the processor reset while high.
REQ-013 busy, done, err  output  1 each  status flags.

Function
REQ-014 Stream format SHALL be: count_hi, count_lo (16-bit big-endian word count N), then 4*N program bytes in address order, then 1 checksum byte.
REQ-015 A byte SHALL be transferred only in a cycle where in_valid and in_ready are both high.
REQ-016 States SHALL be IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE and ERR.
REQ-017 in_ready SHALL be high only in HDR_HI, HDR_LO, DATA and CSUM.
REQ-018 IDLE, DONE or ERR with start=1 SHALL enter HDR_HI next cycle and clear done, err, byte counter and checksum.
REQ-019 start SHALL be ignored in HDR_HI, HDR_LO, DATA and CSUM.
REQ-020 HDR_HI SHALL latch count_hi on transfer and go to HDR_LO.
REQ-021 HDR_LO SHALL latch count_lo on transfer and go to ERR if N > IM_BYTES/4, to CSUM if N = 0, else to DATA.
REQ-022 Each DATA transfer SHALL produce, in the next cycle, im_we=1, im_addr=byte counter, im_wdata=in_data, and SHALL increment the counter (one-cycle registered latency).
REQ-023 DATA SHALL go to CSUM after byte 4*N-1 transfers; byte order is big-endian, so the byte at address 4k is instruction bits 31:24.
REQ-024 Checksum SHALL be the 8-bit modulo-256 sum of all program bytes; header bytes are excluded.
REQ-025 On CSUM transfer: go to DONE if (sum + checksum byte) mod 256 = 0, else go to ERR.
REQ-026 im_we SHALL be low except the one cycle after each DATA transfer; the counter SHALL never wrap, because REQ-021 bounds N.
REQ-027 busy SHALL be high in HDR_HI through CSUM.
REQ-028 done SHALL be high in DONE only; err SHALL be high in ERR only.
REQ-029 cpu_hold SHALL be high in every state except DONE and SHALL drop in the first cycle of DONE.
REQ-030 in_valid low in any accepting state SHALL stall the state machine with no side effects.

Reset
REQ-031 Reset SHALL force IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, busy=0, done=0, err=0, counter=0, checksum=0.
REQ-032 Reset during a load SHALL abort it immediately; bytes already written are not erased, and the next load requires start.

Structure
REQ-033 The state encoding and the constants IM_BASE=32'h0000_3000 and the header length SHALL live in a shared package used by the loader and the fetch unit.
REQ-034 The design SHALL be a single module with no sub-modules; the checksum accumulator is inline.

Verification
REQ-035 start; stream 00 01 24 08 00 05 CF, in_valid always high -> writes 0:24 1:08 2:00 3:05, then done=1, cpu_hold=0, err=0.
REQ-036 start; header 00 00 then checksum 00 -> no im_we pulses, DONE reached; with checksum 01 -> ERR, err=1, cpu_hold=1.
REQ-037 start; header 01 01 (N=257 > 256) -> ERR immediately after count_lo, no writes, in_ready=0.
REQ-038 N=2 stream with in_valid toggling 1/0 each cycle -> same 8 writes in address order, each one cycle after its transfer, and no writes on idle cycles.
REQ-039 Assert reset after 2 DATA bytes -> IDLE and im_we=0 at once; a new start with a full stream completes normally from address 0.
REQ-040 start pulsed during DATA -> ignored, counter not cleared; start in DONE -> HDR_HI next cycle, done cleared, cpu_hold=1.
